fifo_wr_arbiter: RTL and testbench

Round-robin write-side arbiter that shares one single-port write FIFO (in_wr/in_wdata/out_full interface) among NREQ producers. Grants one producer at a time for a bounded burst, forwards its beats to the FIFO with zero added latency, and never writes when the FIFO reports full. It sits between the producer valid/ready links and the FIFO write port.

---
 rtl/fifo_wr_arbiter_if.sv | 26 ++
 rtl/fifo_wr_arbiter.sv | 97 +++++++++
 tb/tb_fifo_wr_arbiter.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_wr_arbiter_if.sv
// rtl/fifo_wr_arbiter_if.sv - producer links, FIFO write port and grant status of the write arbiter
interface fifo_wr_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = $clog2(NREQ)
) ();
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  fifo_full;
    logic                  fifo_wr;
    logic [WIDTH-1:0]      fifo_wdata;
    logic [IDW-1:0]        grant_id;
    logic                  busy;

    // master: producers plus FIFO status; slave: the arbiter itself
    modport master (
        output req_valid, req_data, fifo_full,
        input  req_ready, fifo_wr, fifo_wdata, grant_id, busy
    );

    modport slave (
        input  req_valid, req_data, fifo_full,
        output req_ready, fifo_wr, fifo_wdata, grant_id, busy
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin bounded-burst arbiter sharing one FIFO write port
module fifo_wr_arbiter #(
    parameter int NREQ      = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4,
    parameter int IDW       = $clog2(NREQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    fifo_wr_arbiter_if.slave bus
);
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t          state;
    logic [IDW-1:0]  owner;
    logic [IDW-1:0]  last_owner;
    logic [CW-1:0]   beat_cnt;
    logic [IDW-1:0]  grant_id_q;
    logic            busy_q;

    logic            found;
    logic [IDW-1:0]  winner;
    int              idx;
    logic            owner_valid;
    logic            xfer;
    logic            last_beat;

    // circular search starting just after the previous owner
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(last_owner) + 1 + k) % NREQ;
            if (!found && bus.req_valid[idx]) begin
                found  = 1'b1;
                winner = IDW'(idx);
            end
        end
    end

    assign owner_valid = bus.req_valid[owner];
    assign xfer        = (state == BURST) && owner_valid && !bus.fifo_full;
    assign last_beat   = (beat_cnt == CW'(MAX_BURST - 1));

    // outputs come straight from state so an asynchronous reset silences them at once
    always_comb begin
        bus.req_ready = '0;
        if (state == BURST && !bus.fifo_full)
            bus.req_ready[owner] = 1'b1;
    end

    assign bus.fifo_wr    = xfer;
    assign bus.fifo_wdata = xfer ? bus.req_data[int'(owner) * WIDTH +: WIDTH] : '0;
    assign bus.grant_id   = grant_id_q;
    assign bus.busy       = busy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= '0;
            last_owner <= IDW'(NREQ - 1);
            beat_cnt   <= '0;
            grant_id_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state      <= BURST;
                        owner      <= winner;
                        grant_id_q <= winner;
                        busy_q     <= 1'b1;
                        beat_cnt   <= '0;
                    end
                end
                BURST: begin
                    // a full stall keeps everything; only a valid drop or the last beat releases
                    if (!owner_valid || (xfer && last_beat)) begin
                        state      <= IDLE;
                        busy_q     <= 1'b0;
                        last_owner <= owner;
                        beat_cnt   <= '0;
                    end else if (xfer) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed and random checks of fifo_wr_arbiter against a queue-based model
module tb_fifo_wr_arbiter;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int MB = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.NREQ(N), .WIDTH(W), .IDW(2)) bus ();

    fifo_wr_arbiter #(.NREQ(N), .WIDTH(W), .MAX_BURST(MB), .IDW(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [7:0] pq [N][$];
    logic [7:0] next_val;
    int m_owner, m_cnt, m_last, m_gid;
    int gq[$];
    int bl[$];
    int wr_total;
    int cur_len;
    logic prev_busy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_cnt   = 0;
        m_last  = N - 1;
        m_gid   = 0;
    endtask

    task automatic push(input int r, input int n);
        repeat (n) begin
            pq[r].push_back(next_val);
            next_val = next_val + 8'd1;
        end
    endtask

    function automatic logic any_pending();
        for (int i = 0; i < N; i++)
            if (pq[i].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic tick(input logic full, input logic rst_v);
        logic [N-1:0] v;
        logic [N-1:0] er;
        logic         ew;
        logic [7:0]   ed;
        int           win;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            v[i] = pq[i].size() > 0;
            bus.req_data[i*W +: W] = v[i] ? pq[i][0] : 8'h00;
        end
        bus.req_valid = v;
        bus.fifo_full = full;
        rst_n = rst_v;
        if (!rst_v) model_reset();
        #1;
        er = '0;
        ew = 1'b0;
        ed = 8'h00;
        if (m_owner >= 0) begin
            if (!full) er[m_owner] = 1'b1;
            ew = v[m_owner] && !full;
            if (ew) ed = pq[m_owner][0];
        end
        chk("req_ready", 32'(bus.req_ready), 32'(er));
        chk("fifo_wr", 32'(bus.fifo_wr), 32'(ew));
        chk("fifo_wdata", 32'(bus.fifo_wdata), 32'(ed));
        chk("busy", 32'(bus.busy), 32'(m_owner >= 0));
        chk("grant_id", 32'(bus.grant_id), 32'(m_gid));
        chk("wr_while_full", 32'(bus.fifo_wr & bus.fifo_full), 32'd0);
        chk("ready_onehot0", 32'($onehot0(bus.req_ready)), 32'd1);

        if (bus.busy && !prev_busy) begin
            gq.push_back(int'(bus.grant_id));
            cur_len = 0;
        end
        if (bus.fifo_wr) begin
            cur_len++;
            wr_total++;
        end
        if (!bus.busy && prev_busy) bl.push_back(cur_len);
        prev_busy = bus.busy;

        if (rst_v) begin
            if (m_owner < 0) begin
                win = -1;
                for (int k = 0; k < N; k++)
                    if (win < 0 && v[(m_last + 1 + k) % N]) win = (m_last + 1 + k) % N;
                if (win >= 0) begin
                    m_owner = win;
                    m_gid   = win;
                    m_cnt   = 0;
                end
            end else if (!v[m_owner]) begin
                m_last  = m_owner;
                m_owner = -1;
            end else if (!full) begin
                void'(pq[m_owner].pop_front());
                m_cnt++;
                if (m_cnt == MB) begin
                    m_last  = m_owner;
                    m_owner = -1;
                end
            end
        end
    endtask

    task automatic drain();
        for (int c = 0; c < 400 && any_pending(); c++) tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        chk("drain_done", 32'(any_pending()), 32'd0);
    endtask

    task automatic clear_log();
        gq.delete();
        bl.delete();
        wr_total = 0;
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.fifo_full = 1'b0;
        next_val      = 8'h10;
        prev_busy     = 1'b0;
        cur_len       = 0;
        model_reset();
        clear_log();

        // reset state
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        chk("rst_grant_id", 32'(bus.grant_id), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);

        // all requesters valid: round robin 0,1,2,3,0 with full bursts
        for (int r = 0; r < N; r++) push(r, 8);
        repeat (26) tick(1'b0, 1'b1);
        chk("rr_grants", 32'(gq.size() >= 5), 32'd1);
        if (gq.size() >= 5) begin
            chk("rr_g0", 32'(gq[0]), 32'd0);
            chk("rr_g1", 32'(gq[1]), 32'd1);
            chk("rr_g2", 32'(gq[2]), 32'd2);
            chk("rr_g3", 32'(gq[3]), 32'd3);
            chk("rr_g4", 32'(gq[4]), 32'd0);
        end
        chk("rr_len0", 32'(bl.size() >= 4 ? bl[0] : -1), 32'd4);
        chk("rr_len3", 32'(bl.size() >= 4 ? bl[3] : -1), 32'd4);
        drain();

        // single requester, 10 beats split 4/4/2
        clear_log();
        push(2, 10);
        repeat (16) tick(1'b0, 1'b1);
        chk("solo_writes", 32'(wr_total), 32'd10);
        chk("solo_bursts", 32'(bl.size()), 32'd3);
        if (bl.size() == 3) begin
            chk("solo_len0", 32'(bl[0]), 32'd4);
            chk("solo_len1", 32'(bl[1]), 32'd4);
            chk("solo_len2", 32'(bl[2]), 32'd2);
        end
        foreach (gq[i]) chk("solo_gid", 32'(gq[i]), 32'd2);

        // full stall of 3 cycles after beat 2
        clear_log();
        push(1, 4);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        tick(1'b1, 1'b1);
        chk("stall_beat_cnt", 32'(dut.beat_cnt), 32'd2);
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        chk("stall_writes", 32'(wr_total), 32'd4);
        chk("stall_len", 32'(bl.size() > 0 ? bl[0] : -1), 32'd4);

        // owner drops valid after one beat; requester 3 wins next
        clear_log();
        push(0, 1);
        tick(1'b0, 1'b1);
        push(3, 3);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        chk("drop_grants", 32'(gq.size()), 32'd2);
        if (gq.size() == 2) begin
            chk("drop_g0", 32'(gq[0]), 32'd0);
            chk("drop_g1", 32'(gq[1]), 32'd3);
        end
        chk("drop_len0", 32'(bl.size() > 0 ? bl[0] : -1), 32'd1);
        drain();

        // reset asserted during beat 3
        push(1, 6);
        push(3, 2);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        chk("rst_mid_wr", 32'(bus.fifo_wr), 32'd0);
        chk("rst_mid_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_mid_left", 32'(pq[1].size()), 32'd4);
        tick(1'b0, 1'b0);
        clear_log();
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        chk("rst_first_grant", 32'(gq.size() > 0 ? gq[0] : -1), 32'd1);
        drain();

        // random traffic with random fifo_full
        for (int c = 0; c < 600; c++) begin
            for (int r = 0; r < N; r++)
                if ($urandom_range(3) == 0 && pq[r].size() < 6) push(r, 1 + $urandom_range(2));
            tick($urandom_range(9) < 3, 1'b1);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
